// File: rtl/store_word_bank_if.sv
// ----------------------------------------------------------------------------
// store_word_bank_if
//   Request/response bundle for the store_word_bank scratch store.
//   Optional macro: STORE_WORD_BANK_BYTE_MASK_EN adds the per-byte write_mask.
//
//   Signals
//     write_enable  write request
//     write_addr    write entry index            [ADDR_W]
//     data_in       write data                   [DATA_W]
//     write_mask    byte enables (macro only)    [DATA_W/8]
//     read_enable   read request
//     read_addr     read entry index             [ADDR_W]
//     data_out      registered read data         [DATA_W]
//     output_enable read result valid strobe
//     read_miss     read hit an unwritten or out-of-range entry
//
//   Modports
//     master  drives requests, observes results (datapath / testbench)
//     slave   the store itself
// ----------------------------------------------------------------------------
interface store_word_bank_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 3
);
  logic              write_enable;
  logic [ADDR_W-1:0] write_addr;
  logic [DATA_W-1:0] data_in;
`ifdef STORE_WORD_BANK_BYTE_MASK_EN
  logic [DATA_W/8-1:0] write_mask;
`endif
  logic              read_enable;
  logic [ADDR_W-1:0] read_addr;
  logic [DATA_W-1:0] data_out;
  logic              output_enable;
  logic              read_miss;

  modport master (
    output write_enable, write_addr, data_in,
`ifdef STORE_WORD_BANK_BYTE_MASK_EN
    output write_mask,
`endif
    output read_enable, read_addr,
    input  data_out, output_enable, read_miss
  );

  modport slave (
    input  write_enable, write_addr, data_in,
`ifdef STORE_WORD_BANK_BYTE_MASK_EN
    input  write_mask,
`endif
    input  read_enable, read_addr,
    output data_out, output_enable, read_miss
  );
endinterface

// File: rtl/store_word_bank.sv
// ----------------------------------------------------------------------------
// store_word_bank
//   DEPTH-entry scratch store of DATA_W-bit words with independent write and
//   read ports. Read data is registered and qualified by output_enable; a
//   per-entry written flag raises read_miss for never-written or out-of-range
//   entries. A same-cycle read of the entry being written returns the new
//   word (write-first).
//
//   Optional macro: STORE_WORD_BANK_BYTE_MASK_EN enables per-byte write masks;
//   an all-zero mask makes the write a no-op.
//
//   Ports
//     clk   clock, rising edge
//     rst   asynchronous reset, active-low
//     bus   store_word_bank_if.slave (requests in, registered results out)
// ----------------------------------------------------------------------------
module store_word_bank #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  store_word_bank_if.slave bus
);
  localparam int NB = DATA_W / 8;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

  word_t            mem [DEPTH];
  logic [DEPTH-1:0] written;

  logic          wr_in_range;
  logic          rd_in_range;
  addr_t         wr_idx;
  addr_t         rd_idx;
  logic [NB-1:0] byte_en;
  logic          wr_commit;
  word_t         wr_word;

  logic  oe_d,   oe_q;
  logic  miss_d, miss_q;
  word_t data_d, data_q;

  assign wr_in_range = 32'(bus.write_addr) < DEPTH;
  assign rd_in_range = 32'(bus.read_addr)  < DEPTH;

  // Out-of-range addresses are steered to entry 0 so no array access ever
  // leaves the storage; the in_range qualifiers keep that access harmless.
  assign wr_idx = wr_in_range ? bus.write_addr : '0;
  assign rd_idx = rd_in_range ? bus.read_addr  : '0;

`ifdef STORE_WORD_BANK_BYTE_MASK_EN
  assign byte_en = bus.write_mask;
`else
  assign byte_en = '1;
`endif

  assign wr_commit = bus.write_enable && wr_in_range && (|byte_en);

  // Merge of the current entry with the enabled bytes of data_in. This is
  // both the value stored and the value a same-address read bypasses.
  always_comb begin
    // NOTE: every always_comb output gets a default before any condition,
    // otherwise an untaken branch holds its old value and infers a latch.
    wr_word = mem[wr_idx];
    for (int b = 0; b < NB; b++) begin
      if (byte_en[b]) wr_word[b*8 +: 8] = bus.data_in[b*8 +: 8];
    end
  end

  // The entries must read as zero and unwritten after reset, so the storage
  // is reset along with the flags rather than left to power-up contents.
  // NOTE: clearing a memory in reset forces it into flops; only do it when
  // the reset contents are actually observable, as they are here.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      written <= '0;
    end else if (wr_commit) begin
      mem[wr_idx]     <= wr_word;
      written[wr_idx] <= 1'b1;
    end
  end

  always_comb begin
    oe_d   = 1'b0;
    miss_d = 1'b0;
    data_d = '0;
    if (bus.read_enable) begin
      oe_d = 1'b1;
      if (rd_in_range && wr_commit && (wr_idx == rd_idx)) begin
        data_d = wr_word;
      end else if (rd_in_range && written[rd_idx]) begin
        data_d = mem[rd_idx];
      end else begin
        miss_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      oe_q   <= 1'b0;
      miss_q <= 1'b0;
      data_q <= '0;
    end else begin
      oe_q   <= oe_d;
      miss_q <= miss_d;
      data_q <= data_d;
    end
  end

  assign bus.output_enable = oe_q;
  assign bus.read_miss     = miss_q;
  assign bus.data_out      = data_q;
endmodule

// File: tb/tb_store_word_bank.sv
// ----------------------------------------------------------------------------
// tb_store_word_bank
//   Self-checking bench for store_word_bank (DATA_W=16, DEPTH=6, ADDR_W=3 so
//   addresses 6 and 7 are out of range). Directed scenarios followed by
//   randomized traffic, all compared against an array-based reference model.
//   Byte-mask scenarios run when STORE_WORD_BANK_BYTE_MASK_EN is defined.
// ----------------------------------------------------------------------------
module tb_store_word_bank;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 6;
  localparam int ADDR_W = 3;
  localparam int NB     = DATA_W / 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  store_word_bank_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  store_word_bank #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: plain arrays of words and written flags.
  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                ref_written [DEPTH];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic ref_reset();
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i]     = '0;
      ref_written[i] = 1'b0;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".oe"},   64'(bus.output_enable), 64'd0);
    check({tag, ".data"}, 64'(bus.data_out),      64'd0);
    check({tag, ".miss"}, 64'(bus.read_miss),     64'd0);
  endtask

  // One clock of traffic. The model applies the write before evaluating the
  // read, which gives write-first behaviour for a shared address.
  task automatic step(input bit we, input int wa, input logic [DATA_W-1:0] din,
                      input logic [NB-1:0] mask, input bit re, input int ra,
                      input string tag);
    logic [NB-1:0]     eff_mask;
    logic [DATA_W-1:0] exp_data;
    bit                exp_oe;
    bit                exp_miss;
    @(negedge clk);
    bus.write_enable = we;
    bus.write_addr   = ADDR_W'(wa);
    bus.data_in      = din;
`ifdef STORE_WORD_BANK_BYTE_MASK_EN
    bus.write_mask   = mask;
    eff_mask         = mask;
`else
    eff_mask         = '1;
`endif
    bus.read_enable  = re;
    bus.read_addr    = ADDR_W'(ra);

    if (we && wa < DEPTH) begin
      for (int b = 0; b < NB; b++)
        if (eff_mask[b]) ref_mem[wa][b*8 +: 8] = din[b*8 +: 8];
      if (|eff_mask) ref_written[wa] = 1'b1;
    end
    exp_oe   = re;
    exp_data = '0;
    exp_miss = 1'b0;
    if (re) begin
      if (ra < DEPTH && ref_written[ra]) exp_data = ref_mem[ra];
      else                               exp_miss = 1'b1;
    end

    @(posedge clk);
    #1;
    check({tag, ".oe"},   64'(bus.output_enable), 64'(exp_oe));
    check({tag, ".data"}, 64'(bus.data_out),      64'(exp_data));
    check({tag, ".miss"}, 64'(bus.read_miss),     64'(exp_miss));
  endtask

  task automatic idle(input string tag);
    step(1'b0, 0, '0, '0, 1'b0, 0, tag);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.write_enable = 1'b0;
    bus.write_addr   = '0;
    bus.data_in      = '0;
`ifdef STORE_WORD_BANK_BYTE_MASK_EN
    bus.write_mask   = '0;
`endif
    bus.read_enable  = 1'b0;
    bus.read_addr    = '0;
    ref_reset();

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("por");
    @(negedge clk);
    rst = 1'b1;

    // Reads of untouched entries miss
    step(1'b0, 0, '0, '0, 1'b1, 5, "unwritten5");
    check("unwritten5.const", 64'(bus.read_miss), 64'd1);

    // Write then read, then an idle cycle
    step(1'b1, 0, 16'h00AA, '1, 1'b0, 0, "wr0");
    step(1'b0, 0, '0, '0, 1'b1, 0, "rd0");
    check("rd0.const", 64'(bus.data_out), 64'h00AA);
    idle("after_rd0");

    // Same-address write-first bypass
    step(1'b1, 3, 16'h0055, '1, 1'b1, 3, "bypass3");
    check("bypass3.const", 64'(bus.data_out), 64'h0055);
    // Write one entry while reading another
    step(1'b1, 1, 16'h1111, '1, 1'b1, 0, "wr1_rd0");
    check("wr1_rd0.const", 64'(bus.data_out), 64'h00AA);

    // Out-of-range write dropped, out-of-range read misses
    step(1'b1, 7, 16'h0077, '1, 1'b0, 0, "wr7");
    step(1'b0, 0, '0, '0, 1'b1, 7, "rd7");
    check("rd7.const", 64'(bus.read_miss), 64'd1);
    step(1'b1, 6, 16'h0066, '1, 1'b1, 6, "bypass6_oor");

    // Streaming reads
    step(1'b0, 0, '0, '0, 1'b1, 0, "stream0");
    step(1'b0, 0, '0, '0, 1'b1, 3, "stream1");
    check("stream1.const", 64'(bus.data_out), 64'h0055);
    step(1'b0, 0, '0, '0, 1'b1, 0, "stream2");
    idle("stream_end");

`ifdef STORE_WORD_BANK_BYTE_MASK_EN
    step(1'b1, 1, 16'h1234, 2'b11, 1'b0, 0, "m_full");
    step(1'b1, 1, 16'hABCD, 2'b01, 1'b0, 0, "m_low");
    step(1'b0, 0, '0, '0, 1'b1, 1, "m_rd1");
    check("m_rd1.const", 64'(bus.data_out), 64'h12CD);
    step(1'b1, 4, 16'hBEEF, 2'b00, 1'b0, 0, "m_zero");
    step(1'b0, 0, '0, '0, 1'b1, 4, "m_rd4");
    check("m_rd4.const", 64'(bus.read_miss), 64'd1);
    step(1'b1, 1, 16'hFF00, 2'b10, 1'b1, 1, "m_bypass");
    check("m_bypass.const", 64'(bus.data_out), 64'hFFCD);
    step(1'b1, 0, 16'h9999, 2'b00, 1'b1, 0, "m_zero_bypass");
`endif

    // Mid-run reset with a read result on the outputs and another pending
    step(1'b1, 2, 16'h2222, '1, 1'b1, 2, "pre_rst");
    @(negedge clk);
    bus.write_enable = 1'b0;
    bus.read_enable  = 1'b1;
    bus.read_addr    = ADDR_W'(0);
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    @(posedge clk);
    #1;
    check_idle_outputs("rst_held");
    @(negedge clk);
    rst = 1'b1;
    ref_reset();
    step(1'b0, 0, '0, '0, 1'b1, 2, "post_rst_rd2");
    check("post_rst_rd2.const", 64'(bus.read_miss), 64'd1);

    // Randomized traffic
    for (int n = 0; n < 400; n++) begin
      int wa;
      int ra;
      wa = int'($urandom_range(0, 7));
      ra = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) ra = wa;
      step(bit'($urandom_range(0, 1)), wa, DATA_W'($urandom), NB'($urandom),
           bit'($urandom_range(0, 1)), ra, "rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
